// File: rtl/uart_fifo_tx.sv
// 8N1 serial transmitter that drains a show-ahead byte FIFO, one pop per frame.
// Frames chain straight out of the stop bit when the next byte is already waiting.
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic          bit_end;
  logic          start_frame;

  assign bit_end     = (cnt == CNT_LAST);
  // New frames begin from idle or from the final cycle of a stop bit.
  assign start_frame = enable && !fifo_empty &&
                       ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      tx       <= 1'b1;
      fifo_pop <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      fifo_pop <= 1'b0;
      done     <= 1'b0;
      if (start_frame) begin
        shift    <= fifo_data;
        fifo_pop <= 1'b1;
        tx       <= 1'b0;
        cnt      <= '0;
        busy     <= 1'b1;
        done     <= (state == STOP);
        state    <= START;
      end else begin
        case (state)
          START: begin
            if (bit_end) begin
              cnt     <= '0;
              bit_idx <= '0;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              state   <= DATA;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt <= '0;
              if (bit_idx == 3'd7) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx      <= shift[0];
                shift   <= {1'b0, shift[7:1]};
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STOP: begin
            if (bit_end) begin
              cnt   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: frame-position reference model, FIFO model and serial decoder.
module tb_uart_fifo_tx;
  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop, tx, busy, done;

  uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // FIFO model: show-ahead, error flag on pop-while-empty
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0, rd_ptr = 8'd0;
  logic       fifo_err = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  // Reference model: a frame is a load cycle L plus 10 bit slots of CPB cycles
  logic       m_act = 1'b0, m_pop = 1'b0, m_done = 1'b0, m_tx = 1'b1;
  int         m_L = 0;
  logic [7:0] m_byte = 8'h00;
  logic       rst_seen = 1'b0;
  logic [7:0] exp_q[$];
  // Serial decoder working only from tx
  logic       rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];
  int n_pop = 0, n_done = 0, n_busy = 0, last_pop = 0, last_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick();
    int ph;
    @(posedge CLK);
    cyc++;
    m_pop = 1'b0;
    m_done = 1'b0;
    rst_seen = rst;
    if (rst) m_act = 1'b0;
    else begin
      if (m_act && (cyc - m_L) == 10*CPB) begin
        m_done = 1'b1;
        m_act = 1'b0;
        exp_q.push_back(m_byte);
      end
      if (!m_act && enable && !fifo_empty) begin
        m_act = 1'b1;
        m_L = cyc;
        m_byte = fifo_data;
        m_pop = 1'b1;
      end
    end
    if (m_act) begin
      ph = (cyc - m_L) / CPB;
      m_tx = (ph == 0) ? 1'b0 : (ph == 9) ? 1'b1 : m_byte[ph-1];
    end else m_tx = 1'b1;
    @(negedge CLK);
    chk("tx", tx, m_tx);
    chk("busy", busy, m_act);
    chk("fifo_pop", fifo_pop, m_pop);
    chk("done", done, m_done);
    if (fifo_pop) begin
      n_pop++;
      last_pop = cyc;
      if (fifo_empty) fifo_err = 1'b1;
      else rd_ptr = rd_ptr + 8'd1;
    end
    if (done) begin n_done++; last_done = cyc; end
    if (busy) n_busy++;
    if (rst_seen) rx_on = 1'b0;
    else if (rx_on) begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_byte = {tx, rx_byte[7:1]};
      if (rx_cnt == 38 && tx) rx_q.push_back(rx_byte);
      if (rx_cnt == 39) rx_on = 1'b0;
    end else if (!tx) begin
      rx_on = 1'b1;
      rx_cnt = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    n_pop = 0; n_done = 0; n_busy = 0;
  endtask

  initial begin
    int base;
    logic [7:0] abc [3];
    abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;

    // Reset state
    ticks(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    ticks(2);

    // Single byte
    clr_counts();
    enable = 1'b1;
    base = rx_q.size();
    push(8'h41);
    ticks(50);
    chk("single_pops", n_pop, 1);
    chk("single_done_lat", last_done - last_pop, 40);
    chk("single_busy_after", busy, 1'b0);
    chk("single_rx_n", rx_q.size() - base, 1);
    if (rx_q.size() > base) chk("single_rx", rx_q[base], 8'h41);
    chk("single_err", fifo_err, 1'b0);

    // Back-to-back
    enable = 1'b0;
    push(8'h41); push(8'h42); push(8'h43);
    tick();
    clr_counts();
    base = rx_q.size();
    enable = 1'b1;
    ticks(125);
    chk("b2b_pops", n_pop, 3);
    chk("b2b_busy_cycles", n_busy, 120);
    chk("b2b_dones", n_done, 3);
    chk("b2b_rx_n", rx_q.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (rx_q.size() > base + i) chk("b2b_rx_abc", rx_q[base+i], abc[i]);
    chk("b2b_err", fifo_err, 1'b0);

    // Enable gating
    enable = 1'b0;
    push(8'h5a); push(8'ha5);
    tick();
    clr_counts();
    enable = 1'b1;
    ticks(11);
    enable = 1'b0;
    ticks(60);
    chk("gate_pops", n_pop, 1);
    chk("gate_tx_idle", tx, 1'b1);
    chk("gate_busy", busy, 1'b0);
    enable = 1'b1;
    tick();
    chk("gate_restart_pop", fifo_pop, 1'b1);
    chk("gate_restart_tx", tx, 1'b0);
    ticks(45);

    // Empty FIFO
    clr_counts();
    ticks(100);
    chk("empty_pops", n_pop, 0);
    chk("empty_busy", n_busy, 0);
    chk("empty_err", fifo_err, 1'b0);

    // Reset mid-frame, during data bit 3 of 0x55
    enable = 1'b0;
    push(8'h55); push(8'hc3);
    tick();
    enable = 1'b1;
    tick();
    chk("rstmid_load", fifo_pop, 1'b1);
    ticks(17);
    chk("rstmid_bit3", tx, 1'b0);
    rst = 1'b1;
    tick();
    chk("rstmid_tx", tx, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_pop", fifo_pop, 1'b0);
    rst = 1'b0;
    base = rx_q.size();
    ticks(45);
    chk("rstmid_rx_n", rx_q.size() - base, 1);
    if (rx_q.size() > base) chk("rstmid_rx", rx_q[base], 8'hc3);

    // Slow producer
    for (int i = 0; i < 4; i++) begin
      push(8'($urandom));
      tick();
      chk("slow_start_pop", fifo_pop, 1'b1);
      chk("slow_start_tx", tx, 1'b0);
      ticks(59);
      chk("slow_gap_busy", busy, 1'b0);
    end

    // Random traffic with occasional enable drops and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39, 0) == 0) push(8'($urandom));
      if ($urandom_range(199, 0) == 0) enable = ~enable;
      rst = ($urandom_range(599, 0) == 0);
      tick();
    end
    rst = 1'b0;
    enable = 1'b1;
    ticks(600);
    chk("drain_empty", fifo_empty, 1'b1);
    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) chk("rx_byte", rx_q[i], exp_q[i]);
    chk("final_err", fifo_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
